// File: rtl/spi_master_mc.sv
// spi_master_mc: full-duplex SPI master with run-time mode, bit order and word length,
// a programmable SCLK divider and chip-select setup/hold timing.
module spi_master_mc #(
    parameter int   DW        = 32,
    parameter int   NCS       = 4,
    parameter int   DIVW      = 16,
    parameter logic MOSI_IDLE = 1'b0,
    localparam int  CSW       = $clog2(NCS) | 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CSW-1:0]  cs_sel,
    input  logic [7:0]      nbits,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            lsb_first,
    input  logic [DIVW-1:0] div,
    input  logic [7:0]      cs_setup,
    input  logic [7:0]      cs_hold,
    input  logic [DW-1:0]   tx_data,
    output logic [DW-1:0]   rx_data,
    output logic            busy,
    output logic            done,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic [NCS-1:0]  cs_n
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    localparam logic [7:0] DW8 = 8'(DW);

    state_t          state;
    logic            cpol_q, cpha_q, lsb_q;
    logic [DIVW-1:0] div_q, hcnt;
    logic [7:0]      hold_q, n_q, cnt, bit_cnt;
    logic [DW-1:0]   tx_q, rx_sh, rx_upd;
    logic [NCS-1:0]  cs_dec;
    logic [7:0]      n_eff, tx_k;
    logic            half_end, leading, last_bit, sample_now, shift_now, xfer_end;

    // Position within the word of the k-th bit on the wire.
    function automatic logic [7:0] bit_pos(input logic lsb, input logic [7:0] n,
                                           input logic [7:0] k);
        return lsb ? k : n - 8'd1 - k;
    endfunction

    function automatic logic pick(input logic [DW-1:0] v, input logic [7:0] p);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DW; i++)
            if (8'(i) == p) b = v[i];
        return b;
    endfunction

    always_comb begin
        n_eff = (nbits == 8'd0 || nbits > DW8) ? DW8 : nbits;
        for (int i = 0; i < NCS; i++)
            cs_dec[i] = (CSW'(i) != cs_sel);

        // sclk sitting at its idle level means the next toggle is a leading edge.
        half_end   = (state == XFER) && (hcnt == div_q);
        leading    = (sclk == cpol_q);
        last_bit   = (bit_cnt == n_q - 8'd1);
        sample_now = half_end && (leading ^ cpha_q);
        shift_now  = half_end && (cpha_q ? (leading && bit_cnt != 8'd0)
                                         : (!leading && !last_bit));
        xfer_end   = half_end && !leading && last_bit;
        tx_k       = cpha_q ? bit_cnt : bit_cnt + 8'd1;

        rx_upd = rx_sh;
        if (sample_now)
            for (int i = 0; i < DW; i++)
                if (8'(i) == bit_pos(lsb_q, n_q, bit_cnt)) rx_upd[i] = miso;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            cs_n    <= '1;
            sclk    <= 1'b0;
            mosi    <= MOSI_IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            hold_q  <= '0;
            n_q     <= DW8;
            tx_q    <= '0;
            rx_sh   <= '0;
            cnt     <= '0;
            hcnt    <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle still counts as the tail of the previous transfer.
                    if (start && !done) begin
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        div_q   <= div;
                        hold_q  <= cs_hold;
                        n_q     <= n_eff;
                        tx_q    <= tx_data;
                        busy    <= 1'b1;
                        cs_n    <= cs_dec;
                        sclk    <= cpol;
                        mosi    <= pick(tx_data, bit_pos(lsb_first, n_eff, 8'd0));
                        rx_sh   <= '0;
                        hcnt    <= '0;
                        bit_cnt <= '0;
                        if (cs_setup != 8'd0) begin
                            state <= SETUP;
                            cnt   <= cs_setup - 8'd1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) state <= XFER;
                    else             cnt   <= cnt - 8'd1;
                end
                XFER: begin
                    rx_sh <= rx_upd;
                    if (half_end) begin
                        hcnt <= '0;
                        sclk <= ~sclk;
                        if (shift_now) mosi <= pick(tx_q, bit_pos(lsb_q, n_q, tx_k));
                        if (!leading)  bit_cnt <= bit_cnt + 8'd1;
                        if (xfer_end) begin
                            if (hold_q != 8'd0) begin
                                state <= HOLD;
                                cnt   <= hold_q - 8'd1;
                            end else begin
                                state   <= IDLE;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                cs_n    <= '1;
                                mosi    <= MOSI_IDLE;
                                rx_data <= rx_upd;
                            end
                        end
                    end else begin
                        hcnt <= hcnt + DIVW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cs_n    <= '1;
                        mosi    <= MOSI_IDLE;
                        rx_data <= rx_sh;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed vectors for spi_master_mc with a loopback path and a
// small SPI slave model that answers a fixed byte and records what it hears on mosi.
module tb_spi_master_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cs_sel = '0;
    logic [7:0]  nbits = '0, cs_setup = '0, cs_hold = '0;
    logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [15:0] div = '0;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_data;
    logic        busy, done, sclk, mosi, miso;
    logic [3:0]  cs_n;

    int          vector_count = 0;
    int          miss_count = 0;
    int          rise_count = 0;
    int          cs_low_count = 0;
    int          s_idx = 0;
    int          done_at;
    logic        loopback = 1'b1, slave_miso = 1'b0;
    logic        tb_cpol = 1'b0, tb_cpha = 1'b0;
    logic        prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [7:0]  slave_pat = '0;
    logic [31:0] slave_rx = '0;

    assign miso = loopback ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_master_mc #(.DW(32), .NCS(4), .DIVW(16), .MOSI_IDLE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cs_sel(cs_sel), .nbits(nbits),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div),
        .cs_setup(cs_setup), .cs_hold(cs_hold), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always @(posedge sclk) rise_count++;

    always @(negedge clk) if (cs_n != 4'hF) cs_low_count++;

    // Slave: drives on its shift edge, samples mosi on its sample edge.
    always @(negedge clk) begin
        if (prev_busy && sclk !== prev_sclk) begin
            if (sclk !== tb_cpol) begin
                if (tb_cpha) begin
                    if (s_idx < 8) slave_miso = slave_pat[3'(7 - s_idx)];
                end else begin
                    slave_rx = {slave_rx[30:0], mosi};
                end
            end else begin
                if (tb_cpha) slave_rx = {slave_rx[30:0], mosi};
                s_idx++;
                if (!tb_cpha && s_idx < 8) slave_miso = slave_pat[3'(7 - s_idx)];
            end
        end
        prev_sclk = sclk;
        prev_busy = busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vector_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the cycle after the accepting edge.
    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] nb,
                                 input logic [15:0] dv, input logic [7:0] su,
                                 input logic [7:0] hd, input logic pol, input logic pha,
                                 input logic lsb, input logic [31:0] tx,
                                 input logic [7:0] pat, input logic lb,
                                 input logic hold_start);
        @(negedge clk);
        cs_sel = sel; nbits = nb; div = dv; cs_setup = su; cs_hold = hd;
        cpol = pol; cpha = pha; lsb_first = lsb; tx_data = tx;
        tb_cpol = pol; tb_cpha = pha; slave_pat = pat; loopback = lb;
        s_idx = 0; slave_miso = pat[7]; slave_rx = '0;
        rise_count = 0; cs_low_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = hold_start;
    endtask

    task automatic waitDone(input int limit, output int offs);
        offs = 1;
        while (done !== 1'b1 && offs < limit) begin
            @(negedge clk);
            offs++;
        end
    endtask

    initial begin
        $display("[TB] spi_master_mc directed run");
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_cs_n", 32'(cs_n), 32'hF);
        checkOutput("rst_rx", rx_data, 32'd0);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        rst_n = 1'b1;

        // Mode 0, 8 bits, loopback.
        applyStimulus(3'd0, 8'd8, 16'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0,
                      32'hA5, 8'h00, 1'b1, 1'b0);
        checkOutput("m0_busy", 32'(busy), 32'd1);
        checkOutput("m0_cs_n", 32'(cs_n), 32'hE);
        waitDone(200, done_at);
        checkOutput("m0_done_at", 32'(done_at), 32'd33);
        checkOutput("m0_rx", rx_data, 32'hA5);
        checkOutput("m0_rises", 32'(rise_count), 32'd8);
        checkOutput("m0_cs_off", 32'(cs_n), 32'hF);
        checkOutput("m0_mosi_idle", 32'(mosi), 32'd0);

        // Modes 1..3 against the slave model.
        for (int m = 1; m < 4; m++) begin
            applyStimulus(3'd0, 8'd8, 16'd2, 8'd1, 8'd1, m[1], m[0], 1'b0,
                          32'h3C, 8'hC3, 1'b0, 1'b0);
            waitDone(200, done_at);
            checkOutput("mode_done_at", 32'(done_at), 32'd51);
            checkOutput("mode_rx", rx_data, 32'h0000_00C3);
            checkOutput("mode_slave_rx", slave_rx, 32'h3C);
            @(negedge clk);
            checkOutput("mode_sclk_idle", 32'(sclk), 32'(m[1]));
        end

        // LSB first, 12 bits: mosi sequence 1,0,0,0,0,0,0,0,1,1,1,1.
        applyStimulus(3'd0, 8'd12, 16'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1,
                      32'h0000_0F01, 8'h00, 1'b1, 1'b0);
        waitDone(200, done_at);
        checkOutput("lsb_done_at", 32'(done_at), 32'd49);
        checkOutput("lsb_mosi_seq", slave_rx, 32'h80F);
        checkOutput("lsb_rx", rx_data, 32'h0000_0F01);

        // Asynchronous reset in the middle of a transfer.
        applyStimulus(3'd0, 8'd8, 16'd3, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0,
                      32'hFF, 8'h00, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cs_n", 32'(cs_n), 32'hF);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_rx", rx_data, 32'd0);
        checkOutput("mid_rst_sclk", 32'(sclk), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // nbits=0 means full width; cs 2 with setup/hold.
        applyStimulus(3'd2, 8'd0, 16'd0, 8'd3, 8'd2, 1'b0, 1'b0, 1'b0,
                      32'hDEAD_BEEF, 8'h00, 1'b1, 1'b0);
        checkOutput("full_cs_n", 32'(cs_n), 32'hB);
        waitDone(300, done_at);
        checkOutput("full_done_at", 32'(done_at), 32'd70);
        checkOutput("full_cs_low", 32'(cs_low_count), 32'd69);
        checkOutput("full_rises", 32'(rise_count), 32'd32);
        checkOutput("full_rx", rx_data, 32'hDEAD_BEEF);

        // start held high, out-of-range chip select, config change while busy.
        applyStimulus(3'd7, 8'd4, 16'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0,
                      32'h9, 8'h00, 1'b1, 1'b1);
        checkOutput("hs_busy", 32'(busy), 32'd1);
        tx_data = 32'h6;
        waitDone(100, done_at);
        checkOutput("hs_done_at", 32'(done_at), 32'd9);
        checkOutput("hs_rx", rx_data, 32'h9);
        checkOutput("hs_cs_low", 32'(cs_low_count), 32'd0);
        @(negedge clk);
        checkOutput("hs_done_pulse", 32'(done), 32'd0);
        checkOutput("hs_no_accept", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("hs_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        waitDone(100, done_at);
        checkOutput("hs2_done_at", 32'(done_at), 32'd9);
        checkOutput("hs2_rx", rx_data, 32'h6);
        checkOutput("hs2_cs_low", 32'(cs_low_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
